// File: rtl/data_acquire_if.sv
// Signal bundle between the acquisition front-end, the ADC and the downstream consumer.
// The master modport is the data_acquire side; the slave modport is the environment side.
interface data_acquire_if #(
  parameter int DATA_W = 12
);
  logic              syncro_i;
  logic              adc_data_req_o;
  logic              adc_data_rdy_i;
  logic [DATA_W-1:0] adc_data_i;
  logic [DATA_W-1:0] data_o;
  logic              data_rdy_o;

  modport master (
    input  syncro_i, adc_data_rdy_i, adc_data_i,
    output adc_data_req_o, data_o, data_rdy_o
  );

  modport slave (
    output syncro_i, adc_data_rdy_i, adc_data_i,
    input  adc_data_req_o, data_o, data_rdy_o
  );
endinterface

// File: rtl/data_acquire.sv
// Averaging ADC front-end: on a trigger edge, fetch 2**LOG2_N samples one at a time
// and publish their truncated unsigned mean with a one-cycle valid pulse.
module data_acquire #(
  parameter int DATA_W = 12,
  parameter int LOG2_N = 3
) (
  input  logic           clk_i,
  input  logic           reset_i,
  data_acquire_if.master bus
);

  localparam int                ACC_W       = DATA_W + LOG2_N;
  localparam int                NUM_SAMPLES = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_IDX    = LOG2_N'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LOG2_N-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                data_rdy_q, data_rdy_d;
  logic                req_q, req_d;
  logic                sync_prev_q, rdy_prev_q;
  logic                sync_edge, rdy_edge;

  assign sync_edge = bus.syncro_i & ~sync_prev_q;
  assign rdy_edge  = bus.adc_data_rdy_i & ~rdy_prev_q;

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    data_rdy_d = 1'b0;
    req_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sync_edge) begin
          acc_d   = '0;
          cnt_d   = '0;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rdy_edge) begin
          acc_d = acc_q + ACC_W'(bus.adc_data_i);
          // The mean is loaded with the last sample so it appears together with the pulse.
          if (cnt_q == LAST_IDX) begin
            data_d     = acc_d[ACC_W-1:LOG2_N];
            data_rdy_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            cnt_d   = cnt_q + LOG2_N'(1);
            req_d   = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking '=' stays in always_comb.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      data_rdy_q  <= 1'b0;
      req_q       <= 1'b0;
      // History preset high: an input already high when reset lifts is not an edge.
      sync_prev_q <= 1'b1;
      rdy_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      data_rdy_q  <= data_rdy_d;
      req_q       <= req_d;
      sync_prev_q <= bus.syncro_i;
      rdy_prev_q  <= bus.adc_data_rdy_i;
    end
  end

  assign bus.adc_data_req_o = req_q;
  assign bus.data_o         = data_q;
  assign bus.data_rdy_o     = data_rdy_q;

endmodule

// File: tb/tb_data_acquire.sv
// Directed bench for data_acquire: an ADC model answers each request, and every
// burst's mean, request count and valid-pulse count are compared to hand-computed values.
module tb_data_acquire;

  logic clk = 1'b0;
  logic reset = 1'b1;

  data_acquire_if #(.DATA_W(12)) bus ();

  data_acquire #(.DATA_W(12), .LOG2_N(3)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int rdy_cnt = 0;
  logic [11:0] samples [8];

  always @(negedge clk) begin
    if (bus.adc_data_req_o) req_cnt++;
    if (bus.data_rdy_o)     rdy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One burst: trigger, serve eight requests, check latencies and the mean.
  // abort_after > 0 asserts reset right after that many samples.
  task automatic run_burst(input string tag, input logic [11:0] exp, input bit hold,
                           input bit extra, input int abort_after);
    int req0, rdy0;
    req0 = req_cnt;
    rdy0 = rdy_cnt;
    @(negedge clk) bus.syncro_i = 1'b1;
    @(negedge clk);
    check({tag, " first req latency"}, 32'(bus.adc_data_req_o), 1);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      if (i == 0 && !hold) bus.syncro_i = 1'b0;
      @(negedge clk) bus.adc_data_rdy_i = 1'b0;
      if (extra && i == 3) begin
        repeat (5) @(negedge clk);
        bus.syncro_i = 1'b1;
        repeat (2) @(negedge clk);
        bus.syncro_i = 1'b0;
        repeat (8) @(negedge clk);
      end else begin
        repeat (15) @(negedge clk);
      end
      bus.adc_data_rdy_i = 1'b1;
      bus.adc_data_i     = samples[i];
      if (abort_after == i + 1) begin
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check({tag, " no rdy after abort"}, 32'(rdy_cnt - rdy0), 0);
        check({tag, " data cleared by reset"}, 32'(bus.data_o), 0);
        return;
      end
      @(negedge clk);
      if (i < 7) begin
        check({tag, " next req latency"}, 32'(bus.adc_data_req_o), 1);
      end else begin
        check({tag, " data_rdy latency"}, 32'(bus.data_rdy_o), 1);
        check({tag, " mean"}, 32'(bus.data_o), 32'(exp));
      end
    end
    @(negedge clk);
    check({tag, " data_rdy one cycle"}, 32'(bus.data_rdy_o), 0);
    if (hold) begin
      repeat (10) @(negedge clk);
      bus.syncro_i = 1'b0;
    end
    repeat (20) @(negedge clk);
    check({tag, " request count"}, 32'(req_cnt - req0), 8);
    check({tag, " rdy pulse count"}, 32'(rdy_cnt - rdy0), 1);
    check({tag, " data held"}, 32'(bus.data_o), 32'(exp));
  endtask

  initial begin
    bus.syncro_i       = 1'b0;
    bus.adc_data_rdy_i = 1'b1;
    bus.adc_data_i     = '0;

    // 1: reset, then idle
    repeat (10) @(negedge clk);
    check("reset req", 32'(bus.adc_data_req_o), 0);
    check("reset data_rdy", 32'(bus.data_rdy_o), 0);
    check("reset data", 32'(bus.data_o), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("idle req count", 32'(req_cnt), 0);
    check("idle rdy count", 32'(rdy_cnt), 0);
    check("idle data", 32'(bus.data_o), 0);

    // 2: samples 1..8 -> 36 >> 3 = 4
    samples = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8};
    run_burst("ramp", 12'd4, 1'b0, 1'b0, 0);

    // 3: full scale -> 32760 >> 3 = 4095
    samples = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    run_burst("full scale", 12'd4095, 1'b0, 1'b0, 0);

    // 4: sum 4417 -> 552; syncro held high past the return to idle
    samples = '{12'd92, 12'd65, 12'd4, 12'd222, 12'd0, 12'hFB3, 12'd12, 12'd3};
    run_burst("mixed held sync", 12'd552, 1'b1, 1'b0, 0);

    // 5: ready edge in idle and extra trigger mid-burst are ignored; sum 360 -> 45
    @(negedge clk) bus.adc_data_rdy_i = 1'b0;
    repeat (3) @(negedge clk);
    bus.adc_data_rdy_i = 1'b1;
    bus.adc_data_i     = 12'd999;
    repeat (5) @(negedge clk);
    check("idle rdy edge no req", 32'(bus.adc_data_req_o), 0);
    samples = '{12'd10, 12'd20, 12'd30, 12'd40, 12'd50, 12'd60, 12'd70, 12'd80};
    run_burst("extra trigger", 12'd45, 1'b0, 1'b1, 0);

    // 6: abort after four samples, then a clean burst; sum 16 -> 2
    samples = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    run_burst("abort", 12'd0, 1'b0, 1'b0, 4);
    samples = '{12'd1, 12'd1, 12'd1, 12'd1, 12'd1, 12'd1, 12'd1, 12'd9};
    run_burst("after abort", 12'd2, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
